// File: rtl/iir_pkg.sv
// Shared types and helpers for the time-multiplexed biquad cascade.
// Holds the FSM state type, coefficient slot indices and the output rounding/saturation.
package iir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, SCALE, DONE} state_t;

    localparam logic [2:0] B0 = 3'd0;
    localparam logic [2:0] B1 = 3'd1;
    localparam logic [2:0] B2 = 3'd2;
    localparam logic [2:0] A1 = 3'd3;
    localparam logic [2:0] A2 = 3'd4;

    typedef struct packed {
        logic signed [31:0] y;
        logic               sat;
    } sat_res_t;

    // Round half up by FRAC bits, then clamp into a signed WIDTH-bit range.
    function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                           input int unsigned frac,
                                           input int unsigned width);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t res;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        res.sat = 1'b0;
        res.y   = 32'(r);
        if (r > hi) begin
            res.y   = 32'(hi);
            res.sat = 1'b1;
        end else if (r < lo) begin
            res.y   = 32'(lo);
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Shadow/active coefficient register file; the shadow bank is copied into the
// active bank on every accepted sample so in-flight samples never see writes.
module iir_coef_bank
    import iir_pkg::*;
#(
    parameter int COEFF_W  = 16,
    parameter int FRAC     = 14,
    parameter int NUM_SECT = 2
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               we,
    input  logic [$clog2(5*NUM_SECT)-1:0]      waddr,
    input  logic signed [COEFF_W-1:0]          wdata,
    input  logic                               copy,
    input  logic [$clog2(5*NUM_SECT)-1:0]      raddr,
    output logic signed [COEFF_W-1:0]          rdata
);

    localparam int unsigned NCOEF = 5 * NUM_SECT;
    localparam int unsigned AW    = $clog2(NCOEF);
    localparam logic signed [COEFF_W-1:0] UNITY = COEFF_W'(64'd1 << FRAC);

    logic signed [COEFF_W-1:0] shadow [NCOEF];
    logic signed [COEFF_W-1:0] active [NCOEF];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < NCOEF; i++) begin
                shadow[i] <= ((i % 5) == 32'(B0)) ? UNITY : '0;
                active[i] <= ((i % 5) == 32'(B0)) ? UNITY : '0;
            end
        end else begin
            if (we && (waddr < AW'(NCOEF)))
                shadow[waddr] <= wdata;
            // Non-blocking copy takes the pre-write shadow on a same-edge write.
            if (copy) begin
                for (int unsigned i = 0; i < NCOEF; i++)
                    active[i] <= shadow[i];
            end
        end
    end

    assign rdata = active[raddr];

endmodule

// File: rtl/iir_biquad_cascade_tdm.sv
// Cascade of NUM_SECT direct-form-I biquads sharing one multiplier/accumulator;
// each section takes five MAC cycles and one rounding/saturation cycle.
module iir_biquad_cascade_tdm
    import iir_pkg::*;
#(
    parameter int WIDTH    = 14,
    parameter int COEFF_W  = 16,
    parameter int FRAC     = 14,
    parameter int NUM_SECT = 2,
    parameter int ACC_W    = WIDTH + COEFF_W + 3
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic signed [WIDTH-1:0]           din,
    input  logic                              din_valid,
    input  logic                              coef_we,
    input  logic [$clog2(5*NUM_SECT)-1:0]     coef_addr,
    input  logic signed [COEFF_W-1:0]         coef_wdata,
    input  logic                              clr_state,
    output logic signed [WIDTH-1:0]           dout,
    output logic                              dout_valid,
    output logic                              busy,
    output logic                              sat_flag,
    output logic                              overrun
);

    localparam int unsigned AW = $clog2(5 * NUM_SECT);
    localparam int unsigned SW = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;

    state_t                    state, state_nxt;
    logic [2:0]                k;
    logic [SW-1:0]             sect;
    logic signed [ACC_W-1:0]   acc, acc_base, prod;
    logic signed [WIDTH-1:0]   sec_in, operand, y_sat;
    logic signed [COEFF_W-1:0] coef;
    logic signed [WIDTH-1:0]   x1 [NUM_SECT];
    logic signed [WIDTH-1:0]   x2 [NUM_SECT];
    logic signed [WIDTH-1:0]   y1 [NUM_SECT];
    logic signed [WIDTH-1:0]   y2 [NUM_SECT];
    logic [AW-1:0]             rd_addr;
    logic                      accept, last_sect;
    sat_res_t                  sr;

    assign accept    = (state == IDLE) && din_valid && !clr_state;
    assign last_sect = (sect == SW'(NUM_SECT - 1));
    assign busy      = (state != IDLE);
    assign rd_addr   = AW'(5 * int'(sect) + int'(k));

    iir_coef_bank #(
        .COEFF_W  (COEFF_W),
        .FRAC     (FRAC),
        .NUM_SECT (NUM_SECT)
    ) u_coef_bank (
        .clk   (clk),
        .n_rst (n_rst),
        .we    (coef_we),
        .waddr (coef_addr),
        .wdata (coef_wdata),
        .copy  (accept),
        .raddr (rd_addr),
        .rdata (coef)
    );

    always_comb begin
        operand = '0;
        case (k)
            B0:      operand = sec_in;
            B1:      operand = x1[sect];
            B2:      operand = x2[sect];
            A1:      operand = y1[sect];
            A2:      operand = y2[sect];
            default: operand = '0;
        endcase
        prod     = ACC_W'(coef) * ACC_W'(operand);
        acc_base = (k == B0) ? '0 : acc;
        sr       = sat_round(64'(acc), FRAC, WIDTH);
        y_sat    = WIDTH'(sr.y);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (k == A2) state_nxt = SCALE;
            SCALE:   state_nxt = last_sect ? DONE : MAC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr_state)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            k          <= '0;
            sect       <= '0;
            acc        <= '0;
            sec_in     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sat_flag   <= 1'b0;
            overrun    <= 1'b0;
            for (int unsigned i = 0; i < NUM_SECT; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            dout_valid <= 1'b0;
            if (din_valid && busy)
                overrun <= 1'b1;
            if (clr_state) begin
                k    <= '0;
                sect <= '0;
                for (int unsigned i = 0; i < NUM_SECT; i++) begin
                    x1[i] <= '0;
                    x2[i] <= '0;
                    y1[i] <= '0;
                    y2[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            sec_in <= din;
                            k      <= '0;
                            sect   <= '0;
                        end
                    end
                    MAC: begin
                        acc <= ((k == A1) || (k == A2)) ? acc_base - prod : acc_base + prod;
                        k   <= k + 3'd1;
                    end
                    SCALE: begin
                        // The clamped value is both fed back and passed to the next section.
                        x2[sect] <= x1[sect];
                        x1[sect] <= sec_in;
                        y2[sect] <= y1[sect];
                        y1[sect] <= y_sat;
                        sec_in   <= y_sat;
                        k        <= '0;
                        if (sr.sat)
                            sat_flag <= 1'b1;
                        if (!last_sect)
                            sect <= sect + SW'(1);
                    end
                    DONE: begin
                        dout       <= sec_in;
                        dout_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade_tdm.sv
// Randomised and directed bench for the biquad cascade against a difference-equation model.
module tb_iir_biquad_cascade_tdm;

    localparam int WIDTH    = 14;
    localparam int COEFF_W  = 16;
    localparam int FRAC     = 14;
    localparam int NUM_SECT = 2;
    localparam int NC       = 5 * NUM_SECT;
    localparam int AW       = $clog2(NC);

    logic                      clk = 1'b0;
    logic                      n_rst = 1'b0;
    logic signed [WIDTH-1:0]   din = '0;
    logic                      din_valid = 1'b0;
    logic                      coef_we = 1'b0;
    logic [AW-1:0]             coef_addr = '0;
    logic signed [COEFF_W-1:0] coef_wdata = '0;
    logic                      clr_state = 1'b0;
    logic signed [WIDTH-1:0]   dout;
    logic                      dout_valid, busy, sat_flag, overrun;

    iir_biquad_cascade_tdm #(
        .WIDTH    (WIDTH),
        .COEFF_W  (COEFF_W),
        .FRAC     (FRAC),
        .NUM_SECT (NUM_SECT)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .din        (din),
        .din_valid  (din_valid),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .clr_state  (clr_state),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .sat_flag   (sat_flag),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    always @(posedge clk) cyc++;

    longint sh [NC];
    longint ac [NC];
    longint hx1 [NUM_SECT];
    longint hx2 [NUM_SECT];
    longint hy1 [NUM_SECT];
    longint hy2 [NUM_SECT];
    bit     m_sat = 1'b0;
    bit     m_ovr = 1'b0;
    longint last_out = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_zero_hist();
        for (int s = 0; s < NUM_SECT; s++) begin
            hx1[s] = 0; hx2[s] = 0; hy1[s] = 0; hy2[s] = 0;
        end
    endfunction

    // y = b0*x + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2], rounded and clamped per section.
    function automatic longint model_sample(input longint x);
        longint v, acc, y, hi, lo;
        hi = (longint'(1) << (WIDTH - 1)) - 1;
        lo = -(longint'(1) << (WIDTH - 1));
        v  = x;
        for (int s = 0; s < NUM_SECT; s++) begin
            acc = ac[5*s] * v + ac[5*s+1] * hx1[s] + ac[5*s+2] * hx2[s]
                - ac[5*s+3] * hy1[s] - ac[5*s+4] * hy2[s];
            y = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
            if (y > hi) begin y = hi; m_sat = 1'b1; end
            if (y < lo) begin y = lo; m_sat = 1'b1; end
            hx2[s] = hx1[s]; hx1[s] = v;
            hy2[s] = hy1[s]; hy1[s] = y;
            v = y;
        end
        return v;
    endfunction

    task automatic write_coef(input int addr, input longint val);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = AW'(addr);
        coef_wdata = COEFF_W'(val);
        @(negedge clk);
        coef_we = 1'b0;
        if (addr < NC) sh[addr] = val;
    endtask

    task automatic clear_hist();
        @(negedge clk);
        clr_state = 1'b1;
        @(negedge clk);
        clr_state = 1'b0;
        model_zero_hist();
    endtask

    task automatic start_sample(input longint x, input bit wr, input int waddr,
                                input longint wval, output longint exp);
        @(negedge clk);
        din       = WIDTH'(x);
        din_valid = 1'b1;
        if (wr) begin
            coef_we    = 1'b1;
            coef_addr  = AW'(waddr);
            coef_wdata = COEFF_W'(wval);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        for (int i = 0; i < NC; i++) ac[i] = sh[i];
        if (wr && waddr < NC) sh[waddr] = wval;
        exp = model_sample(x);
        @(negedge clk);
        din_valid = 1'b0;
        coef_we   = 1'b0;
    endtask

    task automatic wait_result(input string tag, input longint exp);
        int lat;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dout_valid) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
        check({tag, "_lat"}, lat, 6 * NUM_SECT + 1);
        check({tag, "_dout"}, $signed(dout), exp);
        if (lat >= 0) last_out = exp;
    endtask

    task automatic run(input string tag, input longint x);
        longint e;
        start_sample(x, 1'b0, 0, 0, e);
        wait_result(tag, e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        longint e;
        int     pulses;

        for (int i = 0; i < NC; i++) begin
            sh[i] = ((i % 5) == 0) ? (longint'(1) << FRAC) : 0;
            ac[i] = sh[i];
        end
        model_zero_hist();

        repeat (3) @(negedge clk);
        check("rst_dout", $signed(dout), 0);
        check("rst_dout_valid", longint'(dout_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_sat", longint'(sat_flag), 0);
        check("rst_ovr", longint'(overrun), 0);
        n_rst = 1'b1;

        run("pass_pos", 1000);
        run("pass_neg", -8192);

        write_coef(0, 4096); write_coef(1, 4096); write_coef(2, 4096);
        clear_hist();
        run("fir0", 4000);
        for (int i = 0; i < 4; i++) run("fir", 0);

        write_coef(1, 0); write_coef(2, 0); write_coef(0, 16384); write_coef(3, -8192);
        clear_hist();
        run("rec0", 1000);
        for (int i = 0; i < 6; i++) run("rec", 0);

        write_coef(3, 0); write_coef(0, 32767);
        clear_hist();
        run("sat_pos", 8191);
        check("sat_flag_set", longint'(sat_flag), longint'(m_sat));
        run("sat_neg", -8192);
        check("sat_flag_sticky", longint'(sat_flag), 1);

        write_coef(0, 16384);
        clear_hist();
        check("ovr_clear", longint'(overrun), 0);
        start_sample(1000, 1'b0, 0, 0, e);
        repeat (2) @(negedge clk);
        din = WIDTH'(7777); din_valid = 1'b1;
        coef_we = 1'b1; coef_addr = AW'(0); coef_wdata = COEFF_W'(8192);
        @(negedge clk);
        din_valid = 1'b0; coef_we = 1'b0;
        sh[0] = 8192; m_ovr = 1'b1;
        wait_result("ovr", e);
        check("ovr_flag", longint'(overrun), 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (dout_valid) pulses++;
        end
        check("ovr_extra_valid", pulses, 0);
        clear_hist();
        run("shadow", 1000);

        start_sample(1000, 1'b1, 0, 16384, e);
        wait_result("simul_wr", e);
        run("simul_next", 1000);

        write_coef(3, -8192);
        clear_hist();
        start_sample(1000, 1'b0, 0, 0, e);
        repeat (4) @(negedge clk);
        clr_state = 1'b1;
        @(posedge clk); #1;
        check("clr_busy", longint'(busy), 0);
        @(negedge clk);
        clr_state = 1'b0;
        model_zero_hist();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (dout_valid) pulses++;
        end
        check("clr_no_valid", pulses, 0);
        check("clr_dout_hold", $signed(dout), last_out);
        run("clr_imp0", 1000);
        run("clr_imp1", 0);
        run("clr_imp2", 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int w = 0; w < int'($urandom_range(1, 3)); w++)
                    write_coef(int'($urandom_range(0, 15)), longint'($signed(16'($urandom))));
            end
            if ($urandom_range(0, 9) == 0) clear_hist();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run("rand", longint'($signed(14'($urandom))));
        end

        check("final_sat", longint'(sat_flag), longint'(m_sat));
        check("final_ovr", longint'(overrun), longint'(m_ovr));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/iir_biquad_cascade_tdm.md
Name: iir_biquad_cascade_tdm

Overview:
- Parametrised successor to the fixed-coefficient single-biquad filter.
- Cascade of NUM_SECT direct-form-I biquads, time-multiplexed onto one signed multiplier and accumulator.
- Implements the full y = b0x0 + b1x1 + b2x2 − a1y1 − a2y2, including the a2 term.
- Coefficients are runtime-writable through a shadow bank. Output is rounded and saturated to WIDTH. Sits between the ADC front-end and the demodulation path, driven by a sample strobe.

Parameters:
- WIDTH, 14: input/output sample width, signed.
- COEFF_W, 16: coefficient width, signed.
- FRAC, 14: coefficient fraction bits. With the defaults this is Q2.14, so |coeff| < 2.
- NUM_SECT, 2: number of cascaded biquad sections, range 1..8.
- ACC_W, WIDTH+COEFF_W+3: accumulator width.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- din  in  WIDTH  signed input sample
- din_valid  in  1  sample strobe
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(5*NUM_SECT)  address = 5*section + k, with k order b0,b1,b2,a1,a2
- coef_wdata  in  COEFF_W  signed coefficient
- clr_state  in  1  synchronous clear of all history; aborts a sample in flight
- dout  out  WIDTH  signed filtered sample
- dout_valid  out  1  one-cycle strobe
- busy  out  1  computation in progress
- sat_flag  out  1  sticky: a saturation has occurred
- overrun  out  1  sticky: din_valid arrived while busy

Behaviour:
- Reset, asynchronous on n_rst low:
  - dout, dout_valid, busy, sat_flag and overrun are all 0.
  - All x/y history registers are 0.
  - Both coefficient banks: b0 = 1<<FRAC, all others 0, so every section passes through.
- Accept: on an edge with din_valid=1, busy=0 and clr_state=0:
  - din is latched.
  - The shadow coefficient bank is copied to the active bank.
  - busy goes to 1 on that edge.
- din_valid while busy=1: the sample is ignored and overrun is set. sat_flag and overrun are cleared only by reset.
- FSM states: IDLE -> MAC (5 cycles, k = 0..4) -> SCALE (1 cycle) -> repeat MAC/SCALE for the next section, or go to DONE -> IDLE.
  - Each section therefore takes 6 cycles.
  - The section input is din for section 0, otherwise the previous section's output.
- MAC:
  - The accumulator is cleared at k=0.
  - acc += coef[k] * operand[k].
  - The a1/a2 products are subtracted.
  - Full-precision signed arithmetic. No overflow is possible at ACC_W.
- SCALE:
  - y = (acc + (1<<(FRAC-1))) >>> FRAC, i.e. round half up.
  - Clamp y to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; set sat_flag if clamped.
  - Shift that section's history: x2<=x1, x1<=x, y2<=y1, y1<=y_sat. The saturated value is what is fed back.
- DONE:
  - dout <= final y. dout_valid = 1 for exactly one cycle. busy deasserts on the same edge.
  - Latency: dout_valid is high in the cycle beginning 6*NUM_SECT+1 edges after the accept edge. This is 13 for NUM_SECT=2.
  - A new sample may be accepted on the edge where dout_valid is high.
- dout holds its value until the next DONE.
- Coefficient writes: coef_we writes the shadow bank at any time. It never affects a sample in flight.
- clr_state:
  - Zeros all history and returns the FSM to IDLE.
  - An in-flight sample is discarded: no dout_valid.
  - dout keeps its last value.
  - Takes priority over accept and over writeback on the same edge.
- Simultaneous coef_we and accept on the same edge: the new coefficient is NOT included in that copy. It applies to the next accept.
- Out-of-range coef_addr (≥ 5*NUM_SECT): the write is ignored.

Decomposition:
- Shared package iir_pkg holds:
  - the state enum (IDLE, MAC, SCALE, DONE);
  - the coefficient index constants B0..A2 = 0..4;
  - the function sat_round(acc) returning the WIDTH-bit result plus a sat bit.
- One sub-module, iir_coef_bank: shadow/active register file plus copy-on-accept logic.
- The MAC datapath and FSM stay in the top module.

Test Plan:
- Reset defaults, NUM_SECT=2: din=1000 with a valid strobe -> dout=1000, with dout_valid exactly 13 cycles after accept. din=−8192 -> −8192.
- FIR impulse: section 0 b0=b1=b2=4096 (0.25), a=0, section 1 default. Impulse 4000 then zeros -> dout 1000, 1000, 1000, 0, 0.
- Recursion with rounding: section 0 b0=16384, a1=−8192 (−0.5). Impulse 1000 -> 1000, 500, 250, 125, 63, 32, 16.
- Saturation: b0=32767, din=8191 -> dout=8191 and sat_flag=1. din=−8192 -> dout=−8192. sat_flag stays 1 afterwards.
- Overrun and shadow:
  - Pulse din_valid again 3 cycles after accept -> overrun=1, exactly one dout_valid.
  - Write b0=8192 mid-computation -> current sample uses the old b0. The next sample of 1000 gives 500, given zero history.
- clr_state: assert clr_state 5 cycles after accept -> no dout_valid, busy=0 next cycle. The next impulse reproduces the response expected from zero history.
